// File: rtl/wb_decoder_pkg.sv
// Shared definitions for the Wishbone aperture decoder: timeout FSM encoding,
// default read data and error-counter width.
package wb_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_TOUT  = 2'd2
    } tout_state_e;

    localparam int          ERR_CNT_W            = 8;
    localparam logic [31:0] DEFAULT_READ_VALUE_C = 32'hBAD_FAB_AC;

endpackage

// File: rtl/wb_default_timeout.sv
// Default-slave timeout engine: terminates stalled or unmapped transfers with a
// one-cycle ACK and records the address and a saturating count of timeouts.
module wb_default_timeout
    import wb_decoder_pkg::*;
#(
    parameter int ADR_W   = 17,
    parameter int CNTR_W  = 3,
    parameter int TIMEOUT = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 slv_ack_i,
    input  logic [ADR_W-1:0]     adr_i,
    input  logic                 err_clr_i,
    output logic                 tout_ack_o,
    output logic                 err_pulse_o,
    output logic [ADR_W-1:0]     err_adr_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    tout_state_e          state_q;
    logic [CNTR_W-1:0]    cnt_q;
    logic                 tout_ack_q;
    logic                 err_pulse_q;
    logic [ADR_W-1:0]     err_adr_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // The counter holds the index of the current cycle of the transfer, so
    // expiry at TIMEOUT-1 places the timeout ACK in cycle TIMEOUT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tout_ack_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_adr_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            tout_ack_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            if (err_clr_i) begin
                err_cnt_q <= '0;
                err_adr_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cyc_i && stb_i && !slv_ack_i) begin
                        state_q <= ST_COUNT;
                        cnt_q   <= CNTR_W'(1);
                    end
                end
                ST_COUNT: begin
                    if (slv_ack_i || !(cyc_i && stb_i)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNTR_W'(TIMEOUT - 1)) begin
                        state_q     <= ST_TOUT;
                        cnt_q       <= '0;
                        tout_ack_q  <= 1'b1;
                        err_pulse_q <= 1'b1;
                        err_adr_q   <= adr_i;
                        // A clear landing with a new timeout counts that timeout.
                        if (err_clr_i)
                            err_cnt_q <= ERR_CNT_W'(1);
                        else if (err_cnt_q != '1)
                            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CNTR_W'(1);
                    end
                end
                ST_TOUT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign tout_ack_o  = tout_ack_q;
    assign err_pulse_o = err_pulse_q;
    assign err_adr_o   = err_adr_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/wb_aperture_decoder.sv
// Wishbone address decoder: fixed-size apertures per slave, zero-latency ACK and
// data return, with a default-slave timeout for unmapped or stalled accesses.
module wb_aperture_decoder
    import wb_decoder_pkg::*;
#(
    parameter int                              NUM_SLAVES           = 4,
    parameter int                              APERWIDTH            = 17,
    parameter int                              APERSIZE             = 10,
    parameter logic [NUM_SLAVES*APERWIDTH-1:0] SLV_BASE_ADR         = {17'h03000, 17'h02000, 17'h01000, 17'h00000},
    parameter logic [NUM_SLAVES-1:0]           SLV_BYTE0_QUAL       = 4'b0010,
    parameter logic [NUM_SLAVES-1:0]           SLV_NARROW           = 4'b0010,
    parameter int                              DEFAULT_CNTR_WIDTH   = 3,
    parameter int                              DEFAULT_CNTR_TIMEOUT = 7,
    parameter logic [31:0]                     DEFAULT_READ_VALUE   = DEFAULT_READ_VALUE_C
) (
    input  logic                       WBs_CLK_i,
    input  logic                       WBs_RST_i,
    input  logic [APERWIDTH-1:0]       WBs_ADR_i,
    input  logic                       WBs_CYC_i,
    input  logic [3:0]                 WBs_BYTE_STB_i,
    input  logic                       WBs_WE_i,
    input  logic                       WBs_RD_i,
    input  logic                       WBs_STB_i,
    output logic [31:0]                WBs_DAT_o,
    output logic                       WBs_ACK_o,
    output logic [NUM_SLAVES-1:0]      Slv_CYC_o,
    input  logic [32*NUM_SLAVES-1:0]   Slv_DAT_i,
    input  logic [NUM_SLAVES-1:0]      Slv_ACK_i,
    input  logic                       Err_Clr_i,
    output logic                       Err_Pulse_o,
    output logic [APERWIDTH-1:0]       Err_Adr_o,
    output logic [ERR_CNT_W-1:0]       Err_Cnt_o
);

    localparam int SLOT_LSB = APERSIZE + 2;
    localparam int SLOT_W   = APERWIDTH - SLOT_LSB;

    logic [NUM_SLAVES-1:0] raw_hit;
    logic [NUM_SLAVES-1:0] hit;
    logic                  slv_ack;
    logic                  tout_ack;
    logic                  unused_byte_stb;

    assign unused_byte_stb = &{1'b0, WBs_BYTE_STB_i[3:1]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
            assign raw_hit[gi] = (WBs_ADR_i[APERWIDTH-1:SLOT_LSB] ==
                                  SLV_BASE_ADR[gi*APERWIDTH+SLOT_LSB +: SLOT_W]);
            // Byte-0 qualified slaves ignore writes that do not touch byte lane 0.
            if (SLV_BYTE0_QUAL[gi]) begin : g_qual
                assign Slv_CYC_o[gi] = hit[gi] & WBs_CYC_i &
                                       ((WBs_WE_i & WBs_BYTE_STB_i[0]) | WBs_RD_i);
            end else begin : g_plain
                assign Slv_CYC_o[gi] = hit[gi] & WBs_CYC_i;
            end
        end
    endgenerate

    // Overlapping apertures resolve to the lowest-index slave.
    always_comb begin
        logic taken;
        taken = 1'b0;
        hit   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i] = raw_hit[i] & ~taken;
            taken  = taken | raw_hit[i];
        end
    end

    always_comb begin
        logic [31:0] word;
        WBs_DAT_o = DEFAULT_READ_VALUE;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            word = Slv_DAT_i[i*32 +: 32];
            if (hit[i])
                WBs_DAT_o = SLV_NARROW[i] ? (word & 32'h0000_FFFF) : word;
        end
        if (tout_ack)
            WBs_DAT_o = DEFAULT_READ_VALUE;
    end

    assign slv_ack   = |(Slv_ACK_i & Slv_CYC_o);
    assign WBs_ACK_o = slv_ack | tout_ack;

    wb_default_timeout #(
        .ADR_W   (APERWIDTH),
        .CNTR_W  (DEFAULT_CNTR_WIDTH),
        .TIMEOUT (DEFAULT_CNTR_TIMEOUT)
    ) u_timeout (
        .clk_i       (WBs_CLK_i),
        .rst_i       (WBs_RST_i),
        .cyc_i       (WBs_CYC_i),
        .stb_i       (WBs_STB_i),
        .slv_ack_i   (slv_ack),
        .adr_i       (WBs_ADR_i),
        .err_clr_i   (Err_Clr_i),
        .tout_ack_o  (tout_ack),
        .err_pulse_o (Err_Pulse_o),
        .err_adr_o   (Err_Adr_o),
        .err_cnt_o   (Err_Cnt_o)
    );

endmodule

// File: tb/tb_wb_aperture_decoder.sv
// Directed bench for wb_aperture_decoder: the driver queues expected ACK latency,
// data and error pulse; an independent monitor compares on every DUT ACK.
module tb_wb_aperture_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] adr;
    logic        cyc, we, rd, stb;
    logic [3:0]  bstb;
    logic [31:0] dat_o;
    logic        ack_o;
    logic [3:0]  slv_cyc;
    logic [127:0] slv_dat;
    logic [3:0]  slv_ack;
    logic        err_clr;
    logic        err_pulse;
    logic [16:0] err_adr;
    logic [7:0]  err_cnt;

    typedef struct {
        int          start;
        int          lat;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    localparam logic [31:0] DEF = 32'hBADFABAC;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_aperture_decoder dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_i      (rst),
        .WBs_ADR_i      (adr),
        .WBs_CYC_i      (cyc),
        .WBs_BYTE_STB_i (bstb),
        .WBs_WE_i       (we),
        .WBs_RD_i       (rd),
        .WBs_STB_i      (stb),
        .WBs_DAT_o      (dat_o),
        .WBs_ACK_o      (ack_o),
        .Slv_CYC_o      (slv_cyc),
        .Slv_DAT_i      (slv_dat),
        .Slv_ACK_i      (slv_ack),
        .Err_Clr_i      (err_clr),
        .Err_Pulse_o    (err_pulse),
        .Err_Adr_o      (err_adr),
        .Err_Cnt_o      (err_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ACK must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack_o), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_latency", 32'(cyc_cnt - e.start), 32'(e.lat));
                    check("read_data", dat_o, e.dat);
                    check("err_pulse", 32'(err_pulse), 32'(e.err));
                end
            end
        end
    end

    task automatic xfer(input logic [16:0] a, input logic w, input logic [3:0] bs,
                        input int slv, input int ack_at, input int clr_at,
                        input logic [3:0] exp_cyc, input int exp_lat,
                        input logic [31:0] exp_dat, input logic exp_err);
        exp_t e;
        bit   done;
        int   seen;
        done = 1'b0;
        seen = -1;
        @(posedge clk); #1;
        adr = a; we = w; rd = ~w; bstb = bs; cyc = 1'b1; stb = 1'b1;
        e.start = cyc_cnt; e.lat = exp_lat; e.dat = exp_dat; e.err = exp_err;
        sb_q.push_back(e);
        for (int k = 0; k < 20 && !done; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            slv_ack = (k == ack_at && slv >= 0) ? 4'(1 << slv) : 4'b0000;
            err_clr = (k == clr_at);
            @(negedge clk);
            if (k == 0)
                check("slv_cyc", 32'(slv_cyc), 32'(exp_cyc));
            if (ack_o) begin
                done = 1'b1;
                seen = k;
            end
        end
        if (!done) begin
            check("ack_bound", 32'(ack_o), 32'd1);
            sb_q.delete();
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rd = 1'b0; bstb = 4'b0000;
        slv_ack = 4'b0000; err_clr = 1'b0;
        $display("xfer adr=%h we=%0d bstb=%b ack_cycle=%0d err_cnt=%0d", a, w, bs, seen, err_cnt);
    endtask

    task automatic timeout_xfer(input logic [16:0] a);
        xfer(a, 1'b0, 4'hF, -1, -1, -1, 4'b0000, 7, DEF, 1'b1);
    endtask

    initial begin
        rst = 1'b1; adr = '0; cyc = 1'b0; we = 1'b0; rd = 1'b0; stb = 1'b0;
        bstb = 4'b0000; slv_ack = 4'b0000; err_clr = 1'b0;
        slv_dat = {32'h55556666, 32'h33334444, 32'hAABB1234, 32'h11112222};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ack", 32'(ack_o), 32'd0);
        check("reset_pulse", 32'(err_pulse), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        check("reset_err_adr", 32'(err_adr), 32'd0);

        // Narrow slave 1 read, ACK in cycle 2, upper half zeroed.
        xfer(17'h01004, 1'b0, 4'hF, 1, 2, -1, 4'b0010, 2, 32'h00001234, 1'b0);
        check("err_cnt_after_read", 32'(err_cnt), 32'd0);

        // Write to slave 1 without byte lane 0: slave not selected, its ACK ignored.
        xfer(17'h01000, 1'b1, 4'b0010, 1, 2, -1, 4'b0000, 7, DEF, 1'b1);
        check("err_cnt_q1", 32'(err_cnt), 32'd1);
        check("err_adr_q1", 32'(err_adr), 32'h01000);

        // Unmapped read.
        timeout_xfer(17'h1F000);
        @(negedge clk);
        check("pulse_one_cycle", 32'(err_pulse), 32'd0);
        check("err_cnt_unmapped", 32'(err_cnt), 32'd2);
        check("err_adr_unmapped", 32'(err_adr), 32'h1F000);

        // Slave ACK in the expiry cycle wins.
        xfer(17'h00010, 1'b0, 4'hF, 0, 6, -1, 4'b0001, 6, 32'h11112222, 1'b0);
        check("err_cnt_expiry_ack", 32'(err_cnt), 32'd2);

        xfer(17'h02008, 1'b1, 4'b0001, 2, 0, -1, 4'b0100, 0, 32'h33334444, 1'b0);
        xfer(17'h03000, 1'b0, 4'hF, 3, 3, -1, 4'b1000, 3, 32'h55556666, 1'b0);
        xfer(17'h01000, 1'b1, 4'b0001, 1, 1, -1, 4'b0010, 1, 32'h00001234, 1'b0);

        // Saturation: 256 timeouts in total.
        for (int n = 0; n < 254; n++)
            timeout_xfer(17'h1F000);
        check("err_cnt_saturated", 32'(err_cnt), 32'hFF);

        // Clear coincident with a new timeout.
        xfer(17'h1E004, 1'b0, 4'hF, -1, -1, 6, 4'b0000, 7, DEF, 1'b1);
        check("clr_coincident_cnt", 32'(err_cnt), 32'd1);
        check("clr_coincident_adr", 32'(err_adr), 32'h1E004);

        timeout_xfer(17'h1D000);
        check("err_cnt_after_clr", 32'(err_cnt), 32'd2);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        check("clr_cnt", 32'(err_cnt), 32'd0);
        check("clr_adr", 32'(err_adr), 32'd0);

        // Reset in cycle 3 of a stalled transfer: no ACK, status zeroed.
        timeout_xfer(17'h1C000);
        check("err_cnt_pre_reset", 32'(err_cnt), 32'd1);
        @(posedge clk); #1;
        adr = 17'h1F000; rd = 1'b1; bstb = 4'hF; cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", 32'(ack_o), 32'd0);
        check("rst_mid_cnt", 32'(err_cnt), 32'd0);
        check("rst_mid_adr", 32'(err_adr), 32'd0);
        check("rst_mid_pulse", 32'(err_pulse), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; rd = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("post_rst_cnt", 32'(err_cnt), 32'd0);
        $display("reset mid-transfer at cycle 3 applied");

        xfer(17'h01004, 1'b0, 4'hF, 1, 2, -1, 4'b0010, 2, 32'h00001234, 1'b0);
        check("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
